// File: rtl/mips_multi_control.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and writeback, with combinational ALU-control decode and PC-enable logic.
module mips_multi_control #(
    parameter int unsigned OP_WIDTH    = 6,
    parameter int unsigned STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_WIDTH-1:0]    opcode_i,
    input  logic [OP_WIDTH-1:0]    funct_i,
    input  logic                   zero_i,
    output logic                   pc_write_o,
    output logic                   pc_en_o,
    output logic                   i_or_d_o,
    output logic                   mem_write_o,
    output logic                   ir_write_o,
    output logic                   reg_dst_o,
    output logic                   mem_to_reg_o,
    output logic                   reg_write_o,
    output logic                   alu_src_a_o,
    output logic                   instr_done_o,
    output logic [1:0]             alu_src_b_o,
    output logic [1:0]             pc_src_o,
    output logic [2:0]             alu_control_o,
    output logic [STATE_WIDTH-1:0] state_o
);

    localparam logic [OP_WIDTH-1:0] OpRtype = OP_WIDTH'(6'h00);
    localparam logic [OP_WIDTH-1:0] OpJ     = OP_WIDTH'(6'h02);
    localparam logic [OP_WIDTH-1:0] OpBeq   = OP_WIDTH'(6'h04);
    localparam logic [OP_WIDTH-1:0] OpAddi  = OP_WIDTH'(6'h08);
    localparam logic [OP_WIDTH-1:0] OpLw    = OP_WIDTH'(6'h23);
    localparam logic [OP_WIDTH-1:0] OpSw    = OP_WIDTH'(6'h2B);

    localparam logic [OP_WIDTH-1:0] FnAdd = OP_WIDTH'(6'h20);
    localparam logic [OP_WIDTH-1:0] FnSub = OP_WIDTH'(6'h22);
    localparam logic [OP_WIDTH-1:0] FnAnd = OP_WIDTH'(6'h24);
    localparam logic [OP_WIDTH-1:0] FnOr  = OP_WIDTH'(6'h25);
    localparam logic [OP_WIDTH-1:0] FnSlt = OP_WIDTH'(6'h2A);

    typedef enum logic [STATE_WIDTH-1:0] {
        StFetch  = STATE_WIDTH'(0),
        StDecode = STATE_WIDTH'(1),
        StMemAdr = STATE_WIDTH'(2),
        StMemRd  = STATE_WIDTH'(3),
        StMemWb  = STATE_WIDTH'(4),
        StMemWr  = STATE_WIDTH'(5),
        StExec   = STATE_WIDTH'(6),
        StAluWb  = STATE_WIDTH'(7),
        StBranch = STATE_WIDTH'(8),
        StAddiEx = STATE_WIDTH'(9),
        StAddiWb = STATE_WIDTH'(10),
        StJump   = STATE_WIDTH'(11)
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [1:0] w_alu_op;
    logic       w_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        pc_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        instr_done_o = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_src_o     = 2'b00;
        w_alu_op     = 2'b00;
        w_branch     = 1'b0;
        case (r_state)
            StFetch: begin
                ir_write_o   = 1'b1;
                pc_write_o   = 1'b1;
                alu_src_b_o  = 2'b01;
                w_state_next = StDecode;
            end
            StDecode: begin
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OpLw, OpSw: w_state_next = StMemAdr;
                    OpRtype:    w_state_next = StExec;
                    OpBeq:      w_state_next = StBranch;
                    OpAddi:     w_state_next = StAddiEx;
                    OpJ:        w_state_next = StJump;
                    default: begin
                        // Unsupported opcode: retire immediately and refetch.
                        w_state_next = StFetch;
                        instr_done_o = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                if (opcode_i == OpLw) begin
                    w_state_next = StMemRd;
                end else if (opcode_i == OpSw) begin
                    w_state_next = StMemWr;
                end
            end
            StMemRd: begin
                i_or_d_o     = 1'b1;
                w_state_next = StMemWb;
            end
            StMemWb: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            StMemWr: begin
                i_or_d_o     = 1'b1;
                mem_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            StExec: begin
                alu_src_a_o  = 1'b1;
                w_alu_op     = 2'b10;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            StBranch: begin
                alu_src_a_o  = 1'b1;
                w_alu_op     = 2'b01;
                pc_src_o     = 2'b01;
                w_branch     = 1'b1;
                instr_done_o = 1'b1;
            end
            StAddiEx: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = 2'b10;
                w_state_next = StAddiWb;
            end
            StAddiWb: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            StJump: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            default: w_state_next = StFetch;
        endcase
    end

    always_comb begin
        alu_control_o = 3'b010;
        case (w_alu_op)
            2'b01: alu_control_o = 3'b110;
            2'b10: begin
                case (funct_i)
                    FnSub:   alu_control_o = 3'b110;
                    FnAnd:   alu_control_o = 3'b000;
                    FnOr:    alu_control_o = 3'b001;
                    FnSlt:   alu_control_o = 3'b111;
                    FnAdd:   alu_control_o = 3'b010;
                    default: alu_control_o = 3'b010;
                endcase
            end
            default: alu_control_o = 3'b010;
        endcase
    end

    assign pc_en_o = pc_write_o | (w_branch & zero_i);
    assign state_o = r_state;

endmodule

// File: tb/tb_mips_multi_control.sv
// Self-checking bench for mips_multi_control: per-cycle expected state/controls are queued
// when an instruction is issued and compared as the FSM steps through it.
module tb_mips_multi_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       pc_write_o, pc_en_o, i_or_d_o, mem_write_o, ir_write_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, instr_done_o;
    logic [1:0] alu_src_b_o, pc_src_o;
    logic [2:0] alu_control_o;
    logic [3:0] state_o;

    mips_multi_control dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .pc_write_o   (pc_write_o),
        .pc_en_o      (pc_en_o),
        .i_or_d_o     (i_or_d_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .instr_done_o (instr_done_o),
        .alu_src_b_o  (alu_src_b_o),
        .pc_src_o     (pc_src_o),
        .alu_control_o(alu_control_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   n_instr = 0;
    logic prev_rw = 1'b0;

    wire [16:0] w_ctl = {pc_write_o, pc_en_o, i_or_d_o, mem_write_o, ir_write_o, reg_dst_o,
                         mem_to_reg_o, reg_write_o, alu_src_a_o, instr_done_o, alu_src_b_o,
                         pc_src_o, alu_control_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] exp_ctl(input int st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z);
        logic pcw, pcen, iord, mw, irw, rd, m2r, rw, srca, done;
        logic [1:0] srcb, psrc;
        logic [2:0] ac;
        {pcw, pcen, iord, mw, irw, rd, m2r, rw, srca, done} = '0;
        srcb = 2'b00;
        psrc = 2'b00;
        ac   = 3'b010;
        case (st)
            0: begin pcw = 1; irw = 1; srcb = 2'b01; end
            1: begin
                srcb = 2'b11;
                done = !(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02});
            end
            2, 9: begin srca = 1; srcb = 2'b10; end
            3: iord = 1;
            4: begin m2r = 1; rw = 1; done = 1; end
            5: begin iord = 1; mw = 1; done = 1; end
            6: begin
                srca = 1;
                case (fn)
                    6'h22: ac = 3'b110;
                    6'h24: ac = 3'b000;
                    6'h25: ac = 3'b001;
                    6'h2A: ac = 3'b111;
                    default: ac = 3'b010;
                endcase
            end
            7: begin rd = 1; rw = 1; done = 1; end
            8: begin srca = 1; ac = 3'b110; psrc = 2'b01; pcen = z; done = 1; end
            10: begin rw = 1; done = 1; end
            11: begin psrc = 2'b10; pcw = 1; done = 1; end
            default: ;
        endcase
        pcen = pcen | pcw;
        return {pcw, pcen, iord, mw, irw, rd, m2r, rw, srca, done, srcb, psrc, ac};
    endfunction

    // Catches back-to-back register writes and counts retirements.
    always @(negedge clk) begin
        #2;
        if (prev_rw) check("rw_twice", {31'd0, reg_write_o}, 32'd0);
        prev_rw = reg_write_o;
        if (instr_done_o === 1'b1) done_cnt++;
    end

    // Called at a negedge with the FSM in FETCH; returns at the negedge after the last state.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input bit scramble, input int glitch_k, input int abort_k);
        int   seq[$];
        exp_t e;
        case (op)
            6'h23:   seq = '{0, 1, 2, 3, 4};
            6'h2B:   seq = '{0, 1, 2, 5};
            6'h00:   seq = '{0, 1, 6, 7};
            6'h08:   seq = '{0, 1, 9, 10};
            6'h04:   seq = '{0, 1, 8};
            6'h02:   seq = '{0, 1, 11};
            default: seq = '{0, 1};
        endcase
        opcode_i = op;
        funct_i  = fn;
        zero_i   = z;
        foreach (seq[i]) sb_q.push_back('{st: 4'(seq[i]), ctl: exp_ctl(seq[i], op, fn, z)});
        for (int k = 0; k < seq.size(); k++) begin
            if (scramble && k >= 3) begin
                opcode_i = 6'($urandom);
                funct_i  = 6'($urandom);
                zero_i   = 1'($urandom);
            end
            #1;
            e = sb_q.pop_front();
            check("state", {28'd0, state_o}, {28'd0, e.st});
            check("ctl", {15'd0, w_ctl}, {15'd0, e.ctl});
            if (k == glitch_k) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
            if (k == abort_k) begin
                reset = 1'b1;
                sb_q.delete();
                @(negedge clk);
                #1;
                check("abort_state", {28'd0, state_o}, 32'd0);
                check("abort_ctl", {15'd0, w_ctl}, {15'd0, exp_ctl(0, op, fn, z)});
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_instr++;
    endtask

    int         d0, n0, cycles;
    logic [5:0] ops[7];
    logic [5:0] fns[6];

    initial begin
        reset    = 1'b1;
        opcode_i = 6'h00;
        funct_i  = 6'h00;
        zero_i   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", {28'd0, state_o}, 32'd0);
        check("rst_ctl", {15'd0, w_ctl}, {15'd0, exp_ctl(0, 6'h00, 6'h00, 1'b0)});
        reset = 1'b0;

        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1, -1);  // lw
        run_instr(6'h00, 6'h22, 1'b0, 1'b0, 1, -1);   // sub, reset glitch between edges
        run_instr(6'h00, 6'h2A, 1'b0, 1'b0, -1, -1);  // slt
        run_instr(6'h00, 6'h33, 1'b0, 1'b0, -1, -1);  // unknown funct -> add
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1, -1);  // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1, -1);  // beq not taken
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, -1, -1);  // unsupported
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1, -1);  // addi, inputs changed late
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1, -1);  // j
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1, 3);   // lw aborted by reset in MEM_RD
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1, -1);  // sw

        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h11};
        d0 = done_cnt;
        n0 = n_instr;
        cycles = 0;
        while (cycles < 10000) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 6) == 6) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, 1'($urandom), 1'b1, -1, -1);
            cycles += 5;
        end
        #3;
        check("done_count", 32'(done_cnt - d0), 32'(n_instr - n0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multi_control.md
MIPS_MULTI_CONTROL -- requirements
Module: mips_multi_control

Interface
REQ-001 The block SHALL have parameter OP_WIDTH, default 6, giving the width of the opcode and funct fields.
REQ-002 The block SHALL have parameter STATE_WIDTH, default 4, giving the width of the state register and state_o.
REQ-003 Port clk  input  1  rising-edge clock, the only clock; reset is synchronous, active-high.
REQ-004 Port reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 Port opcode_i  input  OP_WIDTH  instruction bits [31:26] from the instruction register.
REQ-006 Port funct_i  input  OP_WIDTH  instruction bits [5:0].
REQ-007 Port zero_i  input  1  ALU zero flag.
REQ-008 Ports pc_write_o, pc_en_o, i_or_d_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, instr_done_o  output  1  datapath controls; reg_write_o drives register_file.reg_write_i.
REQ-009 Ports alu_src_b_o, pc_src_o  output  2  ALU B-operand select and PC source select.
REQ-010 Port alu_control_o  output  3  ALU operation code.
REQ-011 Port state_o  output  STATE_WIDTH  current state encoding, for debug.

Function
REQ-012 The block SHALL be a Moore FSM with one state register: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXECUTE=6, ALU_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11.
REQ-013 Transitions SHALL be: FETCH->DECODE; MEM_ADR->MEM_RD if opcode 0x23, MEM_WR if 0x2B; MEM_RD->MEM_WB; EXECUTE->ALU_WB; ADDI_EX->ADDI_WB; MEM_WB, MEM_WR, ALU_WB, BRANCH, ADDI_WB, JUMP->FETCH.
REQ-014 From DECODE the next state SHALL be MEM_ADR for 0x23/0x2B, EXECUTE for 0x00, BRANCH for 0x04, ADDI_EX for 0x08, JUMP for 0x02, and FETCH for any other opcode (unsupported instruction is dropped).
REQ-015 Encodings 12-15 SHALL go to FETCH on the next edge, with all outputs at their defaults.
REQ-016 Default value of every control output in every state SHALL be 0 unless listed in REQ-017..REQ-020.
REQ-017 FETCH: ir_write=1, pc_write=1, alu_src_b=01, alu_op=00. DECODE: alu_src_b=11, alu_op=00.
REQ-018 MEM_ADR and ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. MEM_RD: i_or_d=1. MEM_WB: mem_to_reg=1, reg_write=1.
REQ-019 MEM_WR: i_or_d=1, mem_write=1. EXECUTE: alu_src_a=1, alu_op=10. ALU_WB: reg_dst=1, reg_write=1. ADDI_WB: reg_write=1.
REQ-020 BRANCH: alu_src_a=1, alu_op=01, pc_src=01, internal branch=1. JUMP: pc_src=10, pc_write=1.
REQ-021 pc_en_o SHALL be combinational: pc_write | (branch & zero_i).
REQ-022 alu_control_o SHALL be decoded combinationally from the internal 2-bit alu_op: 00->010, 01->110.
REQ-023 With alu_op=10, alu_control_o SHALL decode funct_i: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2A->111, any other->010.
REQ-024 instr_done_o SHALL be 1 for exactly one cycle in MEM_WB, MEM_WR, ALU_WB, BRANCH, ADDI_WB, JUMP, and in DECODE when the opcode is unsupported.
REQ-025 Latency in cycles including FETCH SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-026 reg_write_o SHALL never be 1 in two consecutive cycles.
REQ-027 opcode_i and funct_i SHALL be sampled only in the states that use them; changes elsewhere SHALL have no effect.

Reset
REQ-028 reset=1 at a rising edge SHALL force state FETCH from any state, including mid-instruction.
REQ-029 Reset SHALL take priority over every transition.
REQ-030 During and after reset the outputs SHALL be the FETCH values (ir_write=1, pc_write=1, pc_en=1, alu_src_b=01, alu_control=010, state_o=0); all other outputs SHALL be 0.
REQ-031 The block SHALL have no asynchronous behaviour; reset asserted between edges SHALL have no effect until the next edge.

Verification
REQ-032 lw (opcode 0x23) after reset -> states 0,1,2,3,4,0; reg_write_o=1 and mem_to_reg_o=1 only in cycle 5; instr_done_o pulses in cycle 5.
REQ-033 R-type, funct 0x22 -> states 0,1,6,7; alu_control_o=110 in EXECUTE; reg_dst_o=1 and reg_write_o=1 in ALU_WB.
REQ-034 beq with zero_i=1 -> pc_en_o=1, pc_src_o=01 in BRANCH; repeated with zero_i=0 -> pc_en_o=0; both cases return to FETCH.
REQ-035 Opcode 0x3F -> DECODE->FETCH; instr_done_o=1 in DECODE; reg_write_o and mem_write_o stay 0 throughout.
REQ-036 Reset asserted in MEM_RD -> next state FETCH with FETCH outputs; a following sw completes in 4 cycles with mem_write_o=1 only in MEM_WR.
REQ-037 Random opcode/funct stream, 10k cycles -> no illegal state, reg_write_o never high two cycles in a row, and instr_done_o count equals the number of instructions fetched.
